// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory read bus between the fetch stage and
// a synchronous instruction memory.
//   imem_en    : read enable (fetch -> memory)
//   imem_addr  : byte read address, registered by the memory (fetch -> memory)
//   imem_rdata : data for the address registered at the previous edge
//                (memory -> fetch)
interface fetch_pc_unit_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             imem_en;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;

  modport master (output imem_en, output imem_addr, input  imem_rdata);
  modport slave  (input  imem_en, input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF stage of the 5-stage RV32I pipeline. Owns the PC, drives
// the synchronous instruction memory, loads the IF/ID register, and keeps
// fetch / redirect statistics.
// Ports:
//   clk, reset        : clock; synchronous active-low reset
//   i_Stall           : load-use stall from hazard unit (hold PC and IF/ID)
//   i_PcSel, i_BrPC   : redirect request / target from the EX branch unit
//   imem              : instruction memory bus (master side)
//   o_IfId_PC/Inst/Valid : IF/ID pipeline register
//   o_Flush           : squash the ID/EX load this cycle
//   o_Misalign        : sticky, set when a redirect target has BrPC[1:0]!=0
//   o_FetchCnt        : saturating count of valid IF/ID loads
//   o_RedirCnt        : saturating count of accepted redirects
module fetch_pc_unit #(
  parameter int               PC_W  = 9,
  parameter int               INS_W = 32,
  parameter logic [INS_W-1:0] NOP   = 32'h00000013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_Stall,
  input  logic               i_PcSel,
  input  logic [31:0]        i_BrPC,
  fetch_pc_unit_if.master    imem,
  output logic [PC_W-1:0]    o_IfId_PC,
  output logic [INS_W-1:0]   o_IfId_Inst,
  output logic               o_IfId_Valid,
  output logic               o_Flush,
  output logic               o_Misalign,
  output logic [15:0]        o_FetchCnt,
  output logic [15:0]        o_RedirCnt
);
  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] inst;
    logic             vld;
  } ifid_t;

  localparam ifid_t BUBBLE = '{pc: '0, inst: NOP, vld: 1'b0};

  logic [0:0]      r_state;
  logic [PC_W-1:0] r_pc;       // address whose data is on imem_rdata now
  ifid_t           r_ifid;
  logic            r_misalign;
  logic [15:0]     r_fetch_cnt;
  logic [15:0]     r_redir_cnt;

  logic [PC_W-1:0] w_next_pc;
  logic            w_en;
  logic            w_flush;
  logic            w_bubble;
  logic            w_fetch;
  logic            w_redir;

  // Target bits above the PC width are dropped on purpose.
  logic w_unused_brpc_hi;
  assign w_unused_brpc_hi = &{1'b0, i_BrPC[31:PC_W]};

  // Redirect beats stall; BOOT ignores both and primes address 0.
  always_comb begin
    w_next_pc = r_pc;
    w_en      = 1'b0;
    w_flush   = 1'b0;
    w_bubble  = 1'b0;
    w_fetch   = 1'b0;
    w_redir   = 1'b0;
    if (!reset) begin
      w_next_pc = '0;
    end else if (r_state == BOOT) begin
      w_en      = 1'b1;
      w_next_pc = '0;
      w_bubble  = 1'b1;
    end else begin
      w_en = 1'b1;
      if (i_PcSel) begin
        w_next_pc = {i_BrPC[PC_W-1:2], 2'b00};
        w_flush   = 1'b1;
        w_bubble  = 1'b1;
        w_redir   = 1'b1;
      end else if (i_Stall) begin
        w_next_pc = r_pc;           // memory re-reads the same word
      end else begin
        w_fetch   = 1'b1;
        w_next_pc = r_pc + PC_W'(4); // wraps modulo 2^PC_W
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= BOOT;
      r_pc        <= '0;
      r_ifid      <= BUBBLE;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_state <= RUN;
      r_pc    <= w_next_pc;
      if (w_bubble)
        r_ifid <= BUBBLE;
      else if (w_fetch)
        r_ifid <= '{pc: r_pc, inst: imem.imem_rdata, vld: 1'b1};
      if (w_fetch && r_fetch_cnt != 16'hFFFF)
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_redir && r_redir_cnt != 16'hFFFF)
        r_redir_cnt <= r_redir_cnt + 16'd1;
      if (w_redir && |i_BrPC[1:0])
        r_misalign <= 1'b1;
    end
  end

  assign imem.imem_en   = w_en;
  assign imem.imem_addr = w_next_pc;
  assign o_IfId_PC      = r_ifid.pc;
  assign o_IfId_Inst    = r_ifid.inst;
  assign o_IfId_Valid   = r_ifid.vld;
  assign o_Flush        = w_flush;
  assign o_Misalign     = r_misalign;
  assign o_FetchCnt     = r_fetch_cnt;
  assign o_RedirCnt     = r_redir_cnt;
endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Stall = 1'b0;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = 32'h0;
  logic [8:0]  IfId_PC;
  logic [31:0] IfId_Inst;
  logic        IfId_Valid, Flush, Misalign;
  logic [15:0] FetchCnt, RedirCnt;

  fetch_pc_unit_if #(.PC_W(9), .INS_W(32)) bus ();

  fetch_pc_unit #(.PC_W(9), .INS_W(32), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .i_Stall(Stall), .i_PcSel(PcSel), .i_BrPC(BrPC),
    .imem(bus), .o_IfId_PC(IfId_PC), .o_IfId_Inst(IfId_Inst),
    .o_IfId_Valid(IfId_Valid), .o_Flush(Flush), .o_Misalign(Misalign),
    .o_FetchCnt(FetchCnt), .o_RedirCnt(RedirCnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word at byte address A is 0xA0000000 | A.
  logic [8:0] mem_raddr = 9'h0;
  always @(posedge clk) if (bus.imem_en) mem_raddr <= bus.imem_addr;
  assign bus.imem_rdata = 32'hA000_0000 | {23'h0, mem_raddr};

  typedef struct packed { logic [8:0] pc; logic [31:0] inst; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // A plain stall (no redirect, out of reset) leaves IF/ID holding an old
  // valid entry; that is not a new output.
  logic p_hold = 1'b0;
  always @(posedge clk) p_hold <= reset && Stall && !PcSel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [8:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = 32'hA000_0000 | {23'h0, pc};
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every new valid IF/ID load is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (IfId_Valid && !p_hold) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ifid: got pc %h with nothing expected", IfId_PC);
        end else begin
          e = q.pop_front();
          chk("ifid_pc",   {23'h0, IfId_PC}, {23'h0, e.pc});
          chk("ifid_inst", IfId_Inst, e.inst);
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},    {31'h0, IfId_Valid}, 32'h0);
    chk({tag, "_inst"},     IfId_Inst, NOP);
    chk({tag, "_pc"},       {23'h0, IfId_PC}, 32'h0);
    chk({tag, "_fetchcnt"}, {16'h0, FetchCnt}, 32'h0);
    chk({tag, "_redircnt"}, {16'h0, RedirCnt}, 32'h0);
    chk({tag, "_misalign"}, {31'h0, Misalign}, 32'h0);
    chk({tag, "_en"},       {31'h0, bus.imem_en}, 32'h0);
    chk({tag, "_addr"},     {23'h0, bus.imem_addr}, 32'h0);
    chk({tag, "_flush"},    {31'h0, Flush}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    chk_reset_state("rst");

    // Release: BOOT cycle primes address 0, IF/ID stays a bubble
    reset = 1'b1;
    #1;
    chk("boot_en",    {31'h0, bus.imem_en}, 32'h1);
    chk("boot_addr",  {23'h0, bus.imem_addr}, 32'h0);
    chk("boot_flush", {31'h0, Flush}, 32'h0);
    cyc();
    chk("boot_valid", {31'h0, IfId_Valid}, 32'h0);

    // Sequential fetch 0,4,8,C
    push(9'h000); push(9'h004); push(9'h008); push(9'h00C);
    repeat (4) cyc();
    chk("seq_fetchcnt", {16'h0, FetchCnt}, 32'd4);

    // Stall 3 cycles at pc=0x10
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_addr",  {23'h0, bus.imem_addr}, 32'h10);
      chk("stall_flush", {31'h0, Flush}, 32'h0);
      cyc();
      chk("stall_frozen_pc", {23'h0, IfId_PC}, 32'h0C);
      chk("stall_fetchcnt",  {16'h0, FetchCnt}, 32'd4);
    end
    Stall = 1'b0;
    push(9'h010); push(9'h014);
    repeat (2) cyc();

    // Redirect to 0x40 with a stall in the same cycle
    PcSel = 1'b1; Stall = 1'b1; BrPC = 32'h0000_0040;
    #1;
    chk("redir_flush", {31'h0, Flush}, 32'h1);
    chk("redir_addr",  {23'h0, bus.imem_addr}, 32'h40);
    cyc();
    PcSel = 1'b0; Stall = 1'b0;
    chk("redir_bubble",   {31'h0, IfId_Valid}, 32'h0);
    chk("redir_cnt1",     {16'h0, RedirCnt}, 32'd1);
    chk("redir_misalign", {31'h0, Misalign}, 32'h0);
    push(9'h040); push(9'h044);
    repeat (2) cyc();
    chk("redir_fetchcnt", {16'h0, FetchCnt}, 32'd8);

    // Misaligned, out-of-range target, then back-to-back redirect
    PcSel = 1'b1; BrPC = 32'hFFFF_FE46;
    #1;
    chk("mis_addr",  {23'h0, bus.imem_addr}, 32'h044);
    chk("mis_flush", {31'h0, Flush}, 32'h1);
    cyc();
    chk("mis_flag", {31'h0, Misalign}, 32'h1);
    chk("mis_cnt",  {16'h0, RedirCnt}, 32'd2);
    BrPC = 32'h0000_0080;
    #1;
    chk("b2b_addr", {23'h0, bus.imem_addr}, 32'h080);
    cyc();
    PcSel = 1'b0;
    chk("b2b_cnt",    {16'h0, RedirCnt}, 32'd3);
    chk("b2b_bubble", {31'h0, IfId_Valid}, 32'h0);
    push(9'h080);
    cyc();
    chk("mis_sticky", {31'h0, Misalign}, 32'h1);

    // PC wrap 0x1FC -> 0x000
    PcSel = 1'b1; BrPC = 32'h0000_01F4;
    cyc();
    PcSel = 1'b0;
    chk("wrap_redircnt", {16'h0, RedirCnt}, 32'd4);
    push(9'h1F4); push(9'h1F8); push(9'h1FC); push(9'h000); push(9'h004);
    repeat (2) cyc();
    #1;
    chk("wrap_addr", {23'h0, bus.imem_addr}, 32'h000);
    repeat (3) cyc();
    chk("wrap_fetchcnt", {16'h0, FetchCnt}, 32'd14);

    // Mid-stream reset with redirect and stall pending
    reset = 1'b0; PcSel = 1'b1; Stall = 1'b1; BrPC = 32'h0000_0101;
    #1;
    chk("mrst_en",    {31'h0, bus.imem_en}, 32'h0);
    chk("mrst_addr",  {23'h0, bus.imem_addr}, 32'h0);
    chk("mrst_flush", {31'h0, Flush}, 32'h0);
    cyc();
    chk_reset_state("mrst");
    PcSel = 1'b0; Stall = 1'b0; BrPC = 32'h0;

    // Counter saturation over 65540 fetches
    reset = 1'b1;
    cyc();
    for (int i = 0; i < 65540; i++) begin
      push(9'(i * 4));
      cyc();
      if (i == 65534) chk("sat_reach", {16'h0, FetchCnt}, 32'h0000FFFF);
    end
    chk("sat_hold",     {16'h0, FetchCnt}, 32'h0000FFFF);
    chk("sat_redircnt", {16'h0, RedirCnt}, 32'h0);

    // Reset mid-stream returns everything within one edge
    reset = 1'b0;
    cyc();
    chk_reset_state("srst");

    chk("queue_drained", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the program counter, addresses the synchronous instruction memory, and loads the IF/ID pipeline register. It consumes the branch unit's redirect (`PcSel`, `BrPC`) from EX and the hazard unit's `Stall`, and drives `Flush` to the ID/EX register. It also keeps fetch and redirect statistics.

## Interface
- `PC_W`, 9: PC width in bits; byte address into instruction memory.
- `INS_W`, 32: instruction width.
- `NOP`, 32'h00000013: encoding loaded into the IF/ID register as a bubble.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-low.
- `Stall`  in  1  hazard unit load-use stall; hold PC and IF/ID.
- `PcSel`  in  1  branch unit redirect request from EX.
- `BrPC`  in  32  redirect target from the branch unit.
- `imem_en`  out  1  instruction memory read enable.
- `imem_addr`  out  PC_W  instruction memory read address; memory registers it.
- `imem_rdata`  in  INS_W  data for the address registered at the previous edge.
- `IfId_PC`  out  PC_W  IF/ID register: PC of the instruction.
- `IfId_Inst`  out  INS_W  IF/ID register: instruction.
- `IfId_Valid`  out  1  IF/ID register holds a real instruction.
- `Flush`  out  1  squash the ID/EX load this cycle.
- `Misalign`  out  1  sticky flag: a redirect target had `BrPC[1:0]` != 0.
- `FetchCnt`  out  16  count of valid IF/ID loads, saturating.
- `RedirCnt`  out  16  count of accepted redirects, saturating.

## Operation
- Internal `pc` (PC_W bits) is the address whose data is on `imem_rdata` in the current cycle.
- `next_pc` is combinational, and `imem_addr` = `next_pc` at all times outside reset.
- FSM states: BOOT and RUN. Reset puts the FSM in BOOT.
- BOOT (exactly one cycle):
  - `imem_en`=1, `next_pc`=0, `pc` stays 0.
  - IF/ID is loaded with a bubble.
  - `Stall` and `PcSel` are ignored; `Flush`=0.
  - Next state is RUN.
- RUN, priority order:
  1. `PcSel`=1 (redirect beats stall):
     - `next_pc` = {`BrPC[PC_W-1:2]`, 2'b00}; upper `BrPC` bits are dropped.
     - IF/ID is loaded with a bubble.
     - `Flush`=1 (combinational, same cycle).
     - `RedirCnt` increments.
     - If `BrPC[1:0]` != 0, `Misalign` is set.
  2. `Stall`=1: `next_pc` = `pc`, so memory re-reads the same address. IF/ID holds. `Flush`=0.
  3. Otherwise:
     - IF/ID is loaded with {`pc`, `imem_rdata`, 1}.
     - `next_pc` = `pc`+4, modulo 2^PC_W; 0x1FC wraps to 0x000.
     - `FetchCnt` increments.
- A bubble is `IfId_Valid`=0, `IfId_Inst`=`NOP`, `IfId_PC`=0.
- Counters stop at 0xFFFF and never wrap.
- `Misalign` clears only on reset.

## Timing
- While `reset`=0 at an edge:
  - `pc`=0, FSM=BOOT, IF/ID = bubble, `FetchCnt`=`RedirCnt`=0, `Misalign`=0.
  - `imem_en`=0, `imem_addr`=0, `Flush`=0.
- Reset asserted mid-operation behaves identically. Any in-flight redirect or stall is discarded.
- After reset release, the first cycle is BOOT. The instruction at address 0 reaches `IfId_Valid`=1 at the end of the second cycle.
- Steady-state throughput is one instruction per cycle. Fetch latency from `imem_addr` to IF/ID is 1 cycle.
- Redirect penalty is 2 bubbles:
  - The edge ending the `PcSel` cycle loads bubbles into IF/ID and, via `Flush`, into ID/EX.
  - The target's instruction is in IF/ID one edge later.
- `Stall` with `PcSel` in the same cycle is a redirect: the stall is dropped and the wrong-path instruction is squashed.
- Consecutive `PcSel` cycles each retarget. Only the last target is fetched, and each one counts in `RedirCnt`.

## Test plan
- Reset, then release with sequential memory contents (word at A = 0xA0000000|A):
  - Cycle 1: BOOT, `IfId_Valid`=0.
  - Then `IfId_PC` steps 0, 4, 8, …; `FetchCnt` matches the number of valid loads.
- PC wrap, `PC_W`=9: run to `pc`=0x1FC → next `imem_addr`=0x000, and `IfId_PC` goes 0x1FC then 0x000.
- `Stall`=1 for 3 cycles at `pc`=0x10:
  - IF/ID frozen, `imem_addr`=0x10 throughout, `FetchCnt` unchanged.
  - Resumes with 0x10 then 0x14.
- `PcSel`=1, `BrPC`=0x0000_0040, with `Stall`=1 in the same cycle:
  - `Flush`=1 that cycle; next `imem_addr`=0x40.
  - Two bubbles, then `IfId_PC`=0x40.
  - `RedirCnt`=1, `Misalign`=0.
- `PcSel`=1 with `BrPC`=0xFFFF_FE46 → target 0x044, `Misalign`=1 and sticky. A later `reset`=0 clears it.
- Pre-load `FetchCnt` near 0xFFFF by running 65540 fetches → it holds at 0xFFFF. `reset` asserted mid-stream returns all outputs to reset values within one edge.
